digit_scan_driver: RTL

- Downstream consumer of the tens/ones splitter.
- Takes two registered BCD digits and drives a 2-digit multiplexed common-anode 7-segment display.
- Includes per-digit scan timing, an anti-ghosting blank interval, leading-zero suppression and tear-free frame-boundary update.
- Sits between the digit-split stage and the board's segment/digit pins.

---
 rtl/digit_disp_pkg.sv | 40 ++++
 rtl/seg7_encoder.sv | 27 ++
 rtl/digit_scan_driver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/digit_disp_pkg.sv
// rtl/digit_disp_pkg.sv - shared types and constants for the 2-digit scan display
package digit_disp_pkg;

    // Scan sequence: blank before each digit, then light it.
    typedef enum logic [1:0] {
        BLANK_T = 2'd0,
        SHOW_T  = 2'd1,
        BLANK_O = 2'd2,
        SHOW_O  = 2'd3
    } disp_state_e;

    // Active-high segment patterns, bit order {dp,g,f,e,d,c,b,a}; dp always off.
    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h6F;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    // Bit positions inside the {ten,one} digit-enable vector.
    localparam int DIG_ONE = 0;
    localparam int DIG_TEN = 1;

    // Cyclic successor in the scan sequence.
    function automatic disp_state_e next_state(input disp_state_e s);
        case (s)
            BLANK_T: next_state = SHOW_T;
            SHOW_T:  next_state = BLANK_O;
            BLANK_O: next_state = SHOW_O;
            default: next_state = BLANK_T;
        endcase
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// rtl/seg7_encoder.sv - BCD digit to active-high 7-segment pattern
module seg7_encoder
    import digit_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    // Pure lookup; non-BCD codes show a dash so bad upstream data is visible.
    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/digit_scan_driver.sv
// rtl/digit_scan_driver.sv - multiplexed 2-digit 7-segment scan driver
module digit_scan_driver
    import digit_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500,
    parameter int unsigned BLANK_LZ  = 1,
    parameter int unsigned ACT_LOW   = 1
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] Ten_Data,
    input  logic [3:0] One_Data,
    input  logic       Load,
    output logic [7:0] Seg_Out,
    output logic [1:0] Dig_Sel,
    output logic       Frame_Done
);

    localparam logic [31:0] SHOW_LEN  = 32'(SCAN_DIV);
    localparam logic [31:0] BLANK_LEN = 32'(BLANK_CYC);
    localparam logic        LZ_EN     = (BLANK_LZ != 0);
    localparam logic [7:0]  SEG_POL   = (ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [1:0]  DIG_POL   = (ACT_LOW != 0) ? 2'b11 : 2'b00;

    disp_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [3:0]  pend_ten_q, pend_ten_d;
    logic [3:0]  pend_one_q, pend_one_d;
    logic [3:0]  disp_ten_q, disp_ten_d;
    logic [3:0]  disp_one_q, disp_one_d;
    logic [7:0]  seg_out_q, seg_out_d;
    logic [1:0]  dig_sel_q, dig_sel_d;
    logic        frame_done_q, frame_done_d;

    logic [31:0] phase_len;
    logic        phase_end;
    logic        commit;
    logic [3:0]  enc_digit;
    logic [7:0]  enc_seg;
    logic [7:0]  seg_hi;
    logic [1:0]  dig_hi;

    // Phase timing and scan sequencing; run_q holds the counter for the
    // first edge after reset so the opening BLANK_T cycle begins there.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_d     = 1'b1;
        phase_len = (state_q == SHOW_T || state_q == SHOW_O) ? SHOW_LEN : BLANK_LEN;
        phase_end = run_q && (cnt_q == phase_len - 32'd1);
        if (run_q) begin
            if (phase_end) begin
                state_d = next_state(state_q);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    // Pending capture on Load; both digits commit together on SHOW_T entry,
    // using pending as it stood before this edge so frames are never torn.
    always_comb begin
        commit     = phase_end && (state_q == BLANK_T);
        pend_ten_d = Load ? Ten_Data : pend_ten_q;
        pend_one_d = Load ? One_Data : pend_one_q;
        disp_ten_d = commit ? pend_ten_q : disp_ten_q;
        disp_one_d = commit ? pend_one_q : disp_one_q;
    end

    // Single shared encoder, fed with whichever digit the next state shows.
    always_comb begin
        enc_digit = (state_d == SHOW_T) ? disp_ten_d : disp_one_d;
    end

    seg7_encoder u_enc (
        .digit (enc_digit),
        .seg   (enc_seg)
    );

    // Output pattern for the state being entered, polarity applied last.
    always_comb begin
        seg_hi = SEG_OFF;
        dig_hi = 2'b00;
        case (state_d)
            SHOW_T: begin
                if (!(LZ_EN && (disp_ten_d == 4'd0))) begin
                    seg_hi          = enc_seg;
                    dig_hi[DIG_TEN] = 1'b1;
                end
            end
            SHOW_O: begin
                seg_hi          = enc_seg;
                dig_hi[DIG_ONE] = 1'b1;
            end
            default: begin
                seg_hi = SEG_OFF;
                dig_hi = 2'b00;
            end
        endcase
        seg_out_d    = seg_hi ^ SEG_POL;
        dig_sel_d    = dig_hi ^ DIG_POL;
        frame_done_d = phase_end && (state_q == SHOW_O);
    end

    // State, counters, digit registers and registered pin drivers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= BLANK_T;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            pend_ten_q   <= '0;
            pend_one_q   <= '0;
            disp_ten_q   <= '0;
            disp_one_q   <= '0;
            seg_out_q    <= SEG_POL;
            dig_sel_q    <= DIG_POL;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            pend_ten_q   <= pend_ten_d;
            pend_one_q   <= pend_one_d;
            disp_ten_q   <= disp_ten_d;
            disp_one_q   <= disp_one_d;
            seg_out_q    <= seg_out_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Seg_Out    = seg_out_q;
    assign Dig_Sel    = dig_sel_q;
    assign Frame_Done = frame_done_q;

endmodule
